// File: rtl/f_fetch_stage.sv
// Fetch stage: PC register, AdEL detection on the fetch address, and the F/D
// pipeline register with stall hold and exception-entry flush.
module f_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] TEXT_LO    = 32'h0000_3000,
  parameter logic [31:0] TEXT_HI    = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic        stall,
  input  logic [31:0] NPC,
  input  logic        BD_F,
  input  logic [31:0] Instr_F,
  output logic [31:0] PC_F,
  output logic [31:0] PC_D,
  output logic [31:0] Instr_D,
  output logic [4:0]  ExcCode_D,
  output logic        BD_D
);

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  exc_code;
    logic        bd;
  } fd_t;

  localparam fd_t FD_RESET = '{pc: RESET_PC,   instr: 32'h0, exc_code: EXC_NONE, bd: 1'b0};
  localparam fd_t FD_FLUSH = '{pc: HANDLER_PC, instr: 32'h0, exc_code: EXC_NONE, bd: 1'b0};

  logic [31:0] pc_q;
  logic [31:0] pc_next;
  logic        adel_f;
  fd_t         fd_q;
  fd_t         fd_f;
  fd_t         fd_next;

  // Unsigned compares, so a wrapped address such as 0xFFFF_FFFC lands above TEXT_HI.
  assign adel_f = (pc_q[1:0] != 2'b00) || (pc_q < TEXT_LO) || (pc_q > TEXT_HI);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    fd_f.pc       = pc_q;
    fd_f.instr    = adel_f ? 32'h0 : Instr_F;
    fd_f.exc_code = adel_f ? EXC_ADEL : EXC_NONE;
    fd_f.bd       = BD_F;

    pc_next = NPC;
    fd_next = fd_f;
    if (Req) begin
      pc_next = HANDLER_PC;
      fd_next = FD_FLUSH;
    end else if (stall) begin
      pc_next = pc_q;
      fd_next = fd_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
      fd_q <= FD_RESET;
    end else begin
      pc_q <= pc_next;
      fd_q <= fd_next;
    end
  end

  assign PC_F      = pc_q;
  assign PC_D      = fd_q.pc;
  assign Instr_D   = fd_q.instr;
  assign ExcCode_D = fd_q.exc_code;
  assign BD_D      = fd_q.bd;

endmodule

// File: tb/tb_f_fetch_stage.sv
// Directed bench for f_fetch_stage: each step queues its expected post-edge
// outputs, then pops and compares them once the edge has passed.
module tb_f_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        Req;
  logic        stall;
  logic [31:0] NPC;
  logic        BD_F;
  logic [31:0] Instr_F;
  logic [31:0] PC_F;
  logic [31:0] PC_D;
  logic [31:0] Instr_D;
  logic [4:0]  ExcCode_D;
  logic        BD_D;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc_f;
    logic [31:0] pc_d;
    logic [31:0] instr_d;
    logic [4:0]  exc_d;
    logic        bd_d;
  } exp_t;

  exp_t sb[$];

  f_fetch_stage dut (
    .clk       (clk),
    .reset     (reset),
    .Req       (Req),
    .stall     (stall),
    .NPC       (NPC),
    .BD_F      (BD_F),
    .Instr_F   (Instr_F),
    .PC_F      (PC_F),
    .PC_D      (PC_D),
    .Instr_D   (Instr_D),
    .ExcCode_D (ExcCode_D),
    .BD_D      (BD_D)
  );

  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  task automatic compare_all(input exp_t e);
    check({e.tag, ".PC_F"},      PC_F,             e.pc_f);
    check({e.tag, ".PC_D"},      PC_D,             e.pc_d);
    check({e.tag, ".Instr_D"},   Instr_D,          e.instr_d);
    check({e.tag, ".ExcCode_D"}, {27'h0, ExcCode_D}, {27'h0, e.exc_d});
    check({e.tag, ".BD_D"},      {31'h0, BD_D},    {31'h0, e.bd_d});
  endtask

  // Drive one cycle of inputs, queue what must appear after the edge, then compare.
  task automatic step(input string tag, input logic req, input logic stl,
                      input logic [31:0] npc, input logic [31:0] instr, input logic bd,
                      input logic [31:0] e_pc_f, input logic [31:0] e_pc_d,
                      input logic [31:0] e_instr, input logic [4:0] e_exc, input logic e_bd);
    exp_t e;
    Req     = req;
    stall   = stl;
    NPC     = npc;
    Instr_F = instr;
    BD_F    = bd;
    sb.push_back('{tag, e_pc_f, e_pc_d, e_instr, e_exc, e_bd});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    compare_all(e);
  endtask

  initial begin
    exp_t e;
    reset = 1'b1; Req = 1'b0; stall = 1'b0; NPC = 32'h0; BD_F = 1'b0; Instr_F = 32'h0;

    // Reset values, immediately and across an edge with inputs active.
    #1;
    compare_all('{"rst0", 32'h3000, 32'h3000, 32'h0, 5'd0, 1'b0});
    NPC = 32'h5000; Instr_F = 32'hDEAD_BEEF; BD_F = 1'b1;
    @(posedge clk); #1;
    compare_all('{"rst1", 32'h3000, 32'h3000, 32'h0, 5'd0, 1'b0});
    reset = 1'b0;

    // Sequential fetch.
    step("seq0", 0, 0, 32'h3004, 32'hA000_0000, 0, 32'h3004, 32'h3000, 32'hA000_0000, 5'd0, 0);
    step("seq1", 0, 0, 32'h3008, 32'hA000_0001, 0, 32'h3008, 32'h3004, 32'hA000_0001, 5'd0, 0);
    step("seq2", 0, 0, 32'h300C, 32'hA000_0002, 0, 32'h300C, 32'h3008, 32'hA000_0002, 5'd0, 0);
    step("seq3", 0, 0, 32'h3010, 32'hA000_0003, 0, 32'h3010, 32'h300C, 32'hA000_0003, 5'd0, 0);

    // Stall three edges at 0x3010, then release.
    for (int i = 0; i < 3; i++)
      step("stall", 0, 1, 32'h3014, 32'hA000_0004, 1, 32'h3010, 32'h300C, 32'hA000_0003, 5'd0, 0);
    step("unstall", 0, 0, 32'h3014, 32'hA000_0004, 0, 32'h3014, 32'h3010, 32'hA000_0004, 5'd0, 0);

    // Fetch-address exceptions: misaligned, above range, below range, top legal.
    step("ld3002", 0, 0, 32'h3002, 32'hB000_0000, 0, 32'h3002, 32'h3014, 32'hB000_0000, 5'd0, 0);
    step("adel_mis", 0, 0, 32'h7000, 32'hB000_0001, 0, 32'h7000, 32'h3002, 32'h0, 5'd4, 0);
    step("adel_hi",  0, 0, 32'h2FFC, 32'hB000_0002, 0, 32'h2FFC, 32'h7000, 32'h0, 5'd4, 0);
    step("adel_lo",  0, 0, 32'h6FFC, 32'hB000_0003, 0, 32'h6FFC, 32'h2FFC, 32'h0, 5'd4, 0);
    step("top_ok",   0, 0, 32'h3020, 32'hB000_0004, 0, 32'h3020, 32'h6FFC, 32'hB000_0004, 5'd0, 0);

    // Req with stall at 0x3020: redirect and flush win.
    step("req_stall", 1, 1, 32'h3024, 32'hB000_0005, 1, 32'h4180, 32'h4180, 32'h0, 5'd0, 0);

    // Delay-slot flag carried, then cleared by a flush.
    step("bd_set",   0, 0, 32'h4184, 32'h2408_0001, 1, 32'h4184, 32'h4180, 32'h2408_0001, 5'd0, 1);
    step("bd_flush", 1, 0, 32'h4188, 32'hC000_0000, 1, 32'h4180, 32'h4180, 32'h0, 5'd0, 0);

    // Wrap-around address loads as given, then flags AdEL.
    step("wrap_ld",   0, 0, 32'hFFFF_FFFC, 32'hC000_0001, 0, 32'hFFFF_FFFC, 32'h4180, 32'hC000_0001, 5'd0, 0);
    step("wrap_adel", 0, 0, 32'h3040, 32'hC000_0002, 0, 32'h3040, 32'hFFFF_FFFC, 32'h0, 5'd4, 0);

    // Asynchronous reset mid-cycle at 0x3040.
    NPC = 32'h3044; Instr_F = 32'hC000_0003; BD_F = 1'b1;
    #1;
    check("pre_rst.PC_F", PC_F, 32'h3040);
    reset = 1'b1;
    #1;
    compare_all('{"async_rst", 32'h3000, 32'h3000, 32'h0, 5'd0, 1'b0});
    reset = 1'b0;
    step("resume", 0, 0, 32'h3004, 32'hD000_0000, 0, 32'h3004, 32'h3000, 32'hD000_0000, 5'd0, 0);

    check("sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/f_fetch_stage.md
# f_fetch_stage

Fetch-stage PC register plus the F/D pipeline register for the five-stage MIPS CPU with CP0 exceptions. Each cycle it loads the next fetch address selected by `D_NPC`, presents `PC_F` to instruction memory and back to `D_NPC`, and detects fetch-address exceptions (AdEL). It carries PC, instruction, exception code and delay-slot flag into the D stage, with stall hold and exception-entry flush.

## Interface
- `RESET_PC`, 32'h0000_3000, PC loaded on reset
- `HANDLER_PC`, 32'h0000_4180, exception handler entry address
- `TEXT_LO`, 32'h0000_3000, lowest legal instruction address
- `TEXT_HI`, 32'h0000_6FFC, highest legal instruction address
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `Req`  in  1  exception/interrupt request from CP0; redirect to the handler
- `stall`  in  1  hazard stall from the hazard unit; hold PC and the F/D register
- `NPC`  in  32  next fetch address from `D_NPC`
- `BD_F`  in  1  the D-stage instruction is a branch/jump, so the instruction in F is a delay slot
- `Instr_F`  in  32  instruction word read from instruction memory at `PC_F`
- `PC_F`  out  32  current fetch address; drives instruction memory and `D_NPC.PC_F`
- `PC_D`  out  32  PC of the instruction in D
- `Instr_D`  out  32  instruction in D
- `ExcCode_D`  out  5  exception code carried into D; 0 means none
- `BD_D`  out  1  the instruction in D is in a branch delay slot

## Operation
- PC register update, in priority order:
  - `reset` asserted: `PC_F` = `RESET_PC`, asynchronously.
  - `Req` = 1: `PC_F` <= `HANDLER_PC`. This overrides `stall`.
  - `stall` = 1: `PC_F` holds.
  - Otherwise: `PC_F` <= `NPC`.
- Fetch exception check (combinational on `PC_F`). `adel_F` = (`PC_F[1:0]` != 0) OR (`PC_F` < `TEXT_LO`) OR (`PC_F` > `TEXT_HI`). Comparisons are unsigned, 32 bit.
- F-stage values presented to the F/D register:
  - `Instr` = `adel_F` ? 32'h0 : `Instr_F`. The faulting fetch becomes a nop.
  - `ExcCode` = `adel_F` ? 5'd4 (AdEL) : 5'd0.
  - `PC` = `PC_F`; `BD` = `BD_F`.
- F/D register update, in priority order:
  - `reset` asserted: `PC_D` = `RESET_PC`, `Instr_D` = 0, `ExcCode_D` = 0, `BD_D` = 0.
  - `Req` = 1: flush. `PC_D` <= `HANDLER_PC`, `Instr_D` <= 0, `ExcCode_D` <= 0, `BD_D` <= 0. A flushed bubble carries the handler PC so CP0 EPC selection stays valid.
  - `stall` = 1: all D outputs hold.
  - Otherwise: load the F-stage values.
- No other state. The block has two registered groups, PC and F/D, updated together each cycle.

## Timing
- Reset values: `PC_F` = 0x3000, `PC_D` = 0x3000, `Instr_D` = 0, `ExcCode_D` = 0, `BD_D` = 0.
- Reset takes effect immediately, with no clock edge. Deasserting reset mid-operation resumes fetch from 0x3000 on the next edge.
- Latency:
  - `NPC` to `PC_F`: one cycle.
  - `Instr_F` at `PC_F` to `Instr_D`: one cycle.
  - `adel_F` to `ExcCode_D`: one cycle.
- `Req` and `stall` together: `Req` wins. Both registers are redirected and flushed that edge.
- `stall` held N cycles: `PC_F` and all D outputs stay constant for N edges. The first unstalled edge loads `NPC` and the current F values.
- Wrap-around: `NPC` = 0xFFFF_FFFC is loaded as given. The following cycle it flags AdEL, with no overflow handling in this block.
- A misaligned `PC_F` inside the text range still flags AdEL.

## Test plan
- Reset, release, `NPC` = `PC_F`+4 each cycle:
  - `PC_F` goes 0x3000, 0x3004, 0x3008.
  - `Instr_D` and `PC_D` follow one cycle later.
  - All outputs match reset values during reset.
- `stall` = 1 for 3 cycles at `PC_F` = 0x3010: `PC_F`, `PC_D` and `Instr_D` are frozen for 3 edges. On release, `PC_F` <= `NPC`.
- `NPC` = 0x3002, then 0x7000, then 0x2FFC:
  - Each next cycle: `Instr_D` = 0, `ExcCode_D` = 4, `PC_D` = the faulting address.
  - `NPC` = 0x6FFC: no exception.
- `Req` = 1 with `stall` = 1 at `PC_F` = 0x3020: the next cycle has `PC_F` = 0x4180, `PC_D` = 0x4180, `Instr_D` = 0, `ExcCode_D` = 0, `BD_D` = 0.
- `BD_F` = 1 with `Instr_F` = 0x2408_0001: the next cycle has `BD_D` = 1 and `Instr_D` = 0x2408_0001. `BD_D` clears after a `Req` flush.
- Assert `reset` mid-cycle while `PC_F` = 0x3040: `PC_F` becomes 0x3000 before the next edge (asynchronous reset).
